// File: rtl/ad2_channel_sequencer_pkg.sv
// Shared constants for the PmodAD2 (AD7991) channel sequencer: channel count,
// FSM encodings and result-word field positions.
package ad2_channel_sequencer_pkg;

  localparam int ADC_CH_COUNT = 4;
  localparam int ADC_ID_W     = 2;
  localparam int ADC_VAL_W    = 12;

  // Result word layout: [13:12] channel ID, [11:0] conversion value.
  localparam int ADC_ID_LSB   = 12;
  localparam int ADC_ID_MSB   = 13;
  localparam int ADC_VAL_LSB  = 0;
  localparam int ADC_VAL_MSB  = 11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SELECT  = 2'd1;
  localparam logic [1:0] ST_CONV    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  typedef logic [ADC_ID_W-1:0]     ch_idx_t;
  typedef logic [ADC_VAL_W-1:0]    adc_val_t;
  typedef logic [ADC_CH_COUNT-1:0] ch_mask_t;

  function automatic ch_mask_t ch_onehot(input ch_idx_t idx);
    ch_onehot = ch_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/ad2_next_channel.sv
// Priority search for the next enabled channel: lowest set bit strictly above
// idx_i, or the lowest set bit overall when from_start_i is high.
module ad2_next_channel
  import ad2_channel_sequencer_pkg::*;
(
  input  ch_mask_t mask_i,
  input  ch_idx_t  idx_i,
  input  logic     from_start_i,
  output ch_idx_t  next_idx_o,
  output logic     found_o
);

  // Descending scan so the lowest qualifying bit is the last one to win.
  always_comb begin
    next_idx_o = '0;
    found_o    = 1'b0;
    for (int i = ADC_CH_COUNT - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (i > int'(idx_i)))) begin
        next_idx_o = ch_idx_t'(i);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad2_channel_sequencer.sv
// Round-robin conversion scheduler for the 4-channel PmodAD2: restarts the I2C
// master per channel, waits a conversion window, captures and ID-checks results.
module ad2_channel_sequencer
  import ad2_channel_sequencer_pkg::*;
#(
  parameter int RST_CYCLES  = 8,
  parameter int CONV_CYCLES = 200000,
  parameter int FRAME_GAP   = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  ch_mask_i,
  input  logic [15:0] raw_data_i,
  output logic [3:0]  cfg_addr_o,
  output logic        ctrl_rst_o,
  output logic [11:0] ch0_o,
  output logic [11:0] ch1_o,
  output logic [11:0] ch2_o,
  output logic [11:0] ch3_o,
  output logic [3:0]  ch_valid_o,
  output logic        frame_done_o,
  output logic [7:0]  err_cnt_o
);

  localparam int CNT_MAX_A = (CONV_CYCLES > FRAME_GAP) ? CONV_CYCLES : FRAME_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > RST_CYCLES) ? CNT_MAX_A : RST_CYCLES;
  localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  // FRAME_GAP of 0 collapses IDLE to the single cycle that carries frame_done.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'((RST_CYCLES  > 0) ? RST_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'((CONV_CYCLES > 0) ? CONV_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((FRAME_GAP   > 0) ? FRAME_GAP   - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ch_idx_t          ch_idx_q, ch_idx_d;
  ch_mask_t         mask_q, mask_d;
  ch_mask_t         cfg_addr_q, cfg_addr_d;
  logic             ctrl_rst_q, ctrl_rst_d;
  adc_val_t         ch_q [ADC_CH_COUNT];
  adc_val_t         ch_d [ADC_CH_COUNT];
  ch_mask_t         ch_valid_q, ch_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  ch_mask_t search_mask;
  logic     search_from_start;
  ch_idx_t  next_idx;
  logic     next_found;
  logic     id_match;
  logic     unused_raw_bits;

  assign unused_raw_bits = ^raw_data_i[15:14];

  // In IDLE the search runs on the live mask, since mask_q loads on the same edge.
  assign search_from_start = (state_q == ST_IDLE);
  assign search_mask       = search_from_start ? ch_mask_i : mask_q;
  assign id_match          = (raw_data_i[ADC_ID_MSB:ADC_ID_LSB] == ch_idx_q);

  ad2_next_channel u_next_channel (
    .mask_i       (search_mask),
    .idx_i        (ch_idx_q),
    .from_start_i (search_from_start),
    .next_idx_o   (next_idx),
    .found_o      (next_found)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_idx_d     = ch_idx_q;
    mask_d       = mask_q;
    cfg_addr_d   = cfg_addr_q;
    ch_d         = ch_q;
    ch_valid_d   = ch_valid_q;
    frame_done_d = 1'b0;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d  = '0;
          mask_d = ch_mask_i;
          if (next_found) begin
            ch_idx_d   = next_idx;
            cfg_addr_d = ch_onehot(next_idx);
            state_d    = ST_SELECT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SELECT: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_CONV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CONV: begin
        if (cnt_q == CONV_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (id_match) begin
          ch_d[ch_idx_q]       = raw_data_i[ADC_VAL_MSB:ADC_VAL_LSB];
          ch_valid_d[ch_idx_q] = 1'b1;
        end else if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        cnt_d = '0;
        if (next_found) begin
          ch_idx_d   = next_idx;
          cfg_addr_d = ch_onehot(next_idx);
          state_d    = ST_SELECT;
        end else begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
    endcase

    ctrl_rst_d = (state_d == ST_IDLE) || (state_d == ST_SELECT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ch_idx_q     <= '0;
      mask_q       <= '0;
      cfg_addr_q   <= 4'b0001;
      ctrl_rst_q   <= 1'b1;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= '0;
      for (int i = 0; i < ADC_CH_COUNT; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_idx_q     <= ch_idx_d;
      mask_q       <= mask_d;
      cfg_addr_q   <= cfg_addr_d;
      ctrl_rst_q   <= ctrl_rst_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      err_cnt_q    <= err_cnt_d;
      for (int i = 0; i < ADC_CH_COUNT; i++) begin
        ch_q[i] <= ch_d[i];
      end
    end
  end

  assign cfg_addr_o   = cfg_addr_q;
  assign ctrl_rst_o   = ctrl_rst_q;
  assign ch0_o        = ch_q[0];
  assign ch1_o        = ch_q[1];
  assign ch2_o        = ch_q[2];
  assign ch3_o        = ch_q[3];
  assign ch_valid_o   = ch_valid_q;
  assign frame_done_o = frame_done_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_ad2_channel_sequencer.sv
// Scoreboard bench for ad2_channel_sequencer with a behavioural I2C master that
// answers each selected channel with a fixed result word.
module tb_ad2_channel_sequencer;

  localparam int RST_C  = 2;
  localparam int CONV_C = 10;
  localparam int GAP_C  = 5;
  localparam int TXN    = RST_C + CONV_C + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_mask = 4'h0;
  logic [15:0] raw_data;
  logic [3:0]  cfg_addr;
  logic        ctrl_rst;
  logic [11:0] ch0, ch1, ch2, ch3;
  logic [3:0]  ch_valid;
  logic        frame_done;
  logic [7:0]  err_cnt;
  logic        bad_ch1 = 1'b0;

  typedef struct {
    logic [11:0] c0, c1, c2, c3;
    logic [3:0]  v;
    logic [7:0]  e;
    int          per;
  } exp_t;

  exp_t       frame_q[$];
  logic [3:0] cfg_q[$];
  int tests = 0;
  int fails = 0;
  int frames_seen = 0;
  int cyc = 0;
  int last_fd = 0;
  logic ctrl_prev = 1'b1;

  always #5 clk = ~clk;

  ad2_channel_sequencer #(
    .RST_CYCLES  (RST_C),
    .CONV_CYCLES (CONV_C),
    .FRAME_GAP   (GAP_C)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ch_mask_i    (ch_mask),
    .raw_data_i   (raw_data),
    .cfg_addr_o   (cfg_addr),
    .ctrl_rst_o   (ctrl_rst),
    .ch0_o        (ch0),
    .ch1_o        (ch1),
    .ch2_o        (ch2),
    .ch3_o        (ch3),
    .ch_valid_o   (ch_valid),
    .frame_done_o (frame_done),
    .err_cnt_o    (err_cnt)
  );

  // I2C master model: result word {2'b00, id, id*100}; channel 1 can lie about its ID.
  always_comb begin
    raw_data = 16'h0000;
    case (cfg_addr)
      4'b0001: raw_data = {2'b00, 2'd0, 12'd0};
      4'b0010: raw_data = bad_ch1 ? {2'b00, 2'd2, 12'd999} : {2'b00, 2'd1, 12'd100};
      4'b0100: raw_data = {2'b00, 2'd2, 12'd200};
      4'b1000: raw_data = {2'b00, 2'd3, 12'd300};
      default: raw_data = 16'h0000;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] mask, input logic [11:0] c0, input logic [11:0] c1,
                            input logic [11:0] c2, input logic [11:0] c3, input logic [3:0] v,
                            input logic [7:0] e, input int per);
    exp_t x;
    logic [3:0] one;
    one = 4'b0001;
    x.c0 = c0; x.c1 = c1; x.c2 = c2; x.c3 = c3; x.v = v; x.e = e; x.per = per;
    frame_q.push_back(x);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) cfg_q.push_back(one << i);
    end
  endtask

  task automatic wait_frame(input string name);
    int target;
    target = frames_seen + 1;
    for (int k = 0; k < 3000 && frames_seen < target; k++) @(negedge clk);
    if (frames_seen < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d frames required %0d", name, frames_seen, target);
    end
  endtask

  task automatic wait_conv(input logic [3:0] addr);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(negedge clk);
      if (cfg_addr == addr && !ctrl_rst) hit = 1'b1;
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL wait_conv_timeout: got cfg_addr %b required %b in CONV", cfg_addr, addr);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cfg_addr"}, cfg_addr, 4'b0001);
    chk({tag, "_ctrl_rst"}, ctrl_rst, 1'b1);
    chk({tag, "_ch0"}, ch0, 0);
    chk({tag, "_ch1"}, ch1, 0);
    chk({tag, "_ch2"}, ch2, 0);
    chk({tag, "_ch3"}, ch3, 0);
    chk({tag, "_ch_valid"}, ch_valid, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Monitor: a transaction is the SELECT->CONV handoff; a frame is a frame_done pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (ctrl_prev && !ctrl_rst) begin
        $display("[TB] txn cfg_addr=%b raw=%h", cfg_addr, raw_data);
        if (cfg_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cfg_unexpected: got %b required none", cfg_addr);
        end else begin
          chk("cfg_addr_order", cfg_addr, cfg_q.pop_front());
        end
      end
      if (frame_done) begin
        $display("[TB] frame ch=%0d/%0d/%0d/%0d valid=%b err=%0d period=%0d",
                 ch0, ch1, ch2, ch3, ch_valid, err_cnt, cyc - last_fd);
        if (frame_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_unexpected: got frame_done=1 required 0");
        end else begin
          e = frame_q.pop_front();
          chk("frame_ch0", ch0, e.c0);
          chk("frame_ch1", ch1, e.c1);
          chk("frame_ch2", ch2, e.c2);
          chk("frame_ch3", ch3, e.c3);
          chk("frame_valid", ch_valid, e.v);
          chk("frame_err_cnt", err_cnt, e.e);
          if (e.per >= 0) chk("frame_period", cyc - last_fd, e.per);
        end
        frames_seen++;
        last_fd = cyc;
      end
    end
    ctrl_prev = ctrl_rst;
  end

  initial begin
    int ctrl_low;
    int fs_before;

    rst_n   = 1'b0;
    ch_mask = 4'b1010;
    repeat (3) @(negedge clk);
    check_reset("reset");

    push_frame(4'b1010, 12'd0, 12'd100, 12'd0, 12'd300, 4'b1010, 8'd0, -1);
    rst_n = 1'b1;
    wait_frame("mask1010");

    ch_mask = 4'hF;
    push_frame(4'hF, 12'd0, 12'd100, 12'd200, 12'd300, 4'hF, 8'd0, GAP_C + 4 * TXN);
    wait_frame("maskF_a");

    // Mask drops to channel 0 while channel 1 converts: this frame still finishes all four.
    push_frame(4'hF, 12'd0, 12'd100, 12'd200, 12'd300, 4'hF, 8'd0, GAP_C + 4 * TXN);
    wait_conv(4'b0010);
    ch_mask = 4'h1;
    wait_frame("maskF_change");
    push_frame(4'h1, 12'd0, 12'd100, 12'd200, 12'd300, 4'hF, 8'd0, GAP_C + TXN);
    wait_frame("mask1");

    // Reset in the middle of channel 2's conversion window.
    ch_mask = 4'hF;
    push_frame(4'hF, 12'd0, 12'd100, 12'd200, 12'd300, 4'hF, 8'd0, GAP_C + 4 * TXN);
    wait_conv(4'b0100);
    #2;
    rst_n = 1'b0;
    frame_q.delete();
    cfg_q.delete();
    #1;
    check_reset("reset_mid_conv");
    bad_ch1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 300; k++) begin
      push_frame(4'hF, 12'd0, 12'd0, 12'd200, 12'd300, 4'b1101,
                 (k > 255) ? 8'd255 : 8'(k), (k == 1) ? -1 : GAP_C + 4 * TXN);
      wait_frame("bad_id");
    end
    chk("err_cnt_saturated", err_cnt, 8'd255);

    bad_ch1   = 1'b0;
    ch_mask   = 4'h0;
    fs_before = frames_seen;
    ctrl_low  = 0;
    repeat (10 * GAP_C + 10) begin
      @(negedge clk);
      if (!ctrl_rst) ctrl_low++;
    end
    chk("mask0_ctrl_rst_low_cycles", ctrl_low, 0);
    chk("mask0_frames", frames_seen, fs_before);

    ch_mask = 4'b0100;
    push_frame(4'b0100, 12'd0, 12'd0, 12'd200, 12'd300, 4'b1101, 8'd255, -1);
    wait_frame("mask0100");
    ch_mask = 4'h0;
    repeat (20) @(negedge clk);

    chk("frames_pending", frame_q.size(), 0);
    chk("cfg_pending", cfg_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
